// File: rtl/cosim_trace_serializer_if.sv
// Retire-trace lane bundle into the serializer and head-entry bundle out of it.
interface cosim_trace_serializer_if #(
  parameter int unsigned NCOMMIT = 2,
  parameter int unsigned XLEN    = 64
);
  logic [NCOMMIT-1:0]      trace_valid;
  logic [NCOMMIT-1:0]      trace_exception;
  logic [NCOMMIT-1:0]      trace_interrupt;
  logic [NCOMMIT-1:0]      trace_has_wdata;
  logic [NCOMMIT*XLEN-1:0] trace_iaddr;
  logic [NCOMMIT*XLEN-1:0] trace_cause;
  logic [NCOMMIT*XLEN-1:0] trace_wdata;
  logic [NCOMMIT*32-1:0]   trace_insn;

  logic                    out_valid;
  logic                    out_ready;
  logic [63:0]             out_cycle;
  logic [63:0]             out_hartid;
  logic [XLEN-1:0]         out_iaddr;
  logic [31:0]             out_insn;
  logic                    out_exception;
  logic                    out_interrupt;
  logic [XLEN-1:0]         out_cause;
  logic                    out_has_wdata;
  logic [XLEN-1:0]         out_wdata;

  modport master (
    output trace_valid, trace_exception, trace_interrupt, trace_has_wdata,
           trace_iaddr, trace_cause, trace_wdata, trace_insn, out_ready,
    input  out_valid, out_cycle, out_hartid, out_iaddr, out_insn,
           out_exception, out_interrupt, out_cause, out_has_wdata, out_wdata
  );

  modport slave (
    input  trace_valid, trace_exception, trace_interrupt, trace_has_wdata,
           trace_iaddr, trace_cause, trace_wdata, trace_insn, out_ready,
    output out_valid, out_cycle, out_hartid, out_iaddr, out_insn,
           out_exception, out_interrupt, out_cause, out_has_wdata, out_wdata
  );
endinterface

// File: rtl/cosim_trace_serializer.sv
// Compacts per-cycle retire trace events into a FIFO and serializes them one per pop,
// dropping whole groups (with sticky overflow and saturating count) when they do not fit.
module cosim_trace_serializer #(
  parameter int unsigned NCOMMIT = 2,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned XLEN    = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [63:0]              cycle,
  input  logic [63:0]              hartid,
  input  logic                     halt_on_overflow,
  cosim_trace_serializer_if.slave  bus,
  output logic                     overflow,
  output logic [31:0]              drop_count,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic [63:0]     cycle;
    logic [63:0]     hartid;
    logic [XLEN-1:0] iaddr;
    logic [31:0]     insn;
    logic            exception;
    logic            interrupt;
    logic [XLEN-1:0] cause;
    logic            has_wdata;
    logic [XLEN-1:0] wdata;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          lane_entry [NCOMMIT];
  logic [AW-1:0]   wr_idx [NCOMMIT];
  logic [NCOMMIT-1:0] is_event;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW-1:0]   n_events, free_slots;
  logic [32:0]     drop_sum;
  logic            pop, accept, drop;
  entry_t          head;

  // Lane compaction: each event lane gets the next consecutive slot after wr_ptr.
  always_comb begin
    n_events = '0;
    for (int i = 0; i < NCOMMIT; i++) begin
      is_event[i] = bus.trace_valid[i] | bus.trace_exception[i] | bus.trace_interrupt[i];
      wr_idx[i]   = wr_ptr[AW-1:0] + n_events[AW-1:0];
      if (is_event[i]) n_events = n_events + PW'(1);
      lane_entry[i].cycle     = cycle;
      lane_entry[i].hartid    = hartid;
      lane_entry[i].iaddr     = bus.trace_iaddr[i*XLEN +: XLEN];
      lane_entry[i].insn      = bus.trace_insn[i*32 +: 32];
      lane_entry[i].exception = bus.trace_exception[i];
      lane_entry[i].interrupt = bus.trace_interrupt[i];
      lane_entry[i].cause     = bus.trace_cause[i*XLEN +: XLEN];
      lane_entry[i].has_wdata = bus.trace_has_wdata[i];
      lane_entry[i].wdata     = bus.trace_wdata[i*XLEN +: XLEN];
    end
  end

  assign occupancy     = wr_ptr - rd_ptr;
  assign bus.out_valid = (occupancy != '0);
  assign pop           = bus.out_valid & bus.out_ready;
  // A same-cycle pop frees a slot for this cycle's group.
  assign free_slots    = PW'(DEPTH) - occupancy + PW'(pop);
  assign accept        = (n_events != '0) && !(overflow && halt_on_overflow)
                         && (n_events <= free_slots);
  assign drop          = (n_events != '0) && !accept;
  assign drop_sum      = {1'b0, drop_count} + 33'(n_events);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + n_events;
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      if (drop) begin
        overflow   <= 1'b1;
        drop_count <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
      end
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the buffer is empty.
  always_ff @(posedge clock) begin
    if (accept) begin
      for (int i = 0; i < NCOMMIT; i++) begin
        if (is_event[i]) mem[wr_idx[i]] <= lane_entry[i];
      end
    end
  end

  assign head              = bus.out_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign bus.out_cycle     = head.cycle;
  assign bus.out_hartid    = head.hartid;
  assign bus.out_iaddr     = head.iaddr;
  assign bus.out_insn      = head.insn;
  assign bus.out_exception = head.exception;
  assign bus.out_interrupt = head.interrupt;
  assign bus.out_cause     = head.cause;
  assign bus.out_has_wdata = head.has_wdata;
  assign bus.out_wdata     = head.wdata;
endmodule

// File: tb/tb_cosim_trace_serializer.sv
// Directed bench for cosim_trace_serializer: expected entries go into a scoreboard queue,
// an independent monitor pops and compares on every accepted output beat.
module tb_cosim_trace_serializer;
  localparam int unsigned NCOMMIT = 2;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned XLEN    = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] cycle, hartid;
  logic        halt_on_overflow;
  logic        overflow;
  logic [31:0] drop_count;
  logic [4:0]  occupancy;

  cosim_trace_serializer_if #(.NCOMMIT(NCOMMIT), .XLEN(XLEN)) bus ();

  cosim_trace_serializer #(.NCOMMIT(NCOMMIT), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock            (clock),
    .reset            (reset),
    .cycle            (cycle),
    .hartid           (hartid),
    .halt_on_overflow (halt_on_overflow),
    .bus              (bus),
    .overflow         (overflow),
    .drop_count       (drop_count),
    .occupancy        (occupancy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [63:0] cycle;
    logic [63:0] hartid;
    logic [63:0] iaddr;
    logic [31:0] insn;
    logic        exception;
    logic        interrupt;
    logic [63:0] cause;
    logic        has_wdata;
    logic [63:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic begin_cycle(input logic [63:0] cyc, input logic [63:0] hid);
    @(negedge clock);
    cycle                = cyc;
    hartid               = hid;
    bus.trace_valid      = '0;
    bus.trace_exception  = '0;
    bus.trace_interrupt  = '0;
    bus.trace_has_wdata  = '0;
    bus.trace_iaddr      = '0;
    bus.trace_cause      = '0;
    bus.trace_wdata      = '0;
    bus.trace_insn       = '0;
  endtask

  // expect_entry is decided by hand at each call site.
  task automatic set_lane(input int i, input logic v, input logic e, input logic irq,
                          input logic hw, input logic [63:0] ia, input logic [31:0] insn,
                          input logic [63:0] cause, input logic [63:0] wd,
                          input bit expect_entry);
    exp_t x;
    bus.trace_valid[i]                 = v;
    bus.trace_exception[i]             = e;
    bus.trace_interrupt[i]             = irq;
    bus.trace_has_wdata[i]             = hw;
    bus.trace_iaddr[i*XLEN +: XLEN]    = ia;
    bus.trace_insn[i*32 +: 32]         = insn;
    bus.trace_cause[i*XLEN +: XLEN]    = cause;
    bus.trace_wdata[i*XLEN +: XLEN]    = wd;
    if (expect_entry) begin
      x.cycle = cycle;  x.hartid = hartid; x.iaddr = ia;  x.insn = insn;
      x.exception = e;  x.interrupt = irq; x.cause = cause;
      x.has_wdata = hw; x.wdata = wd;
      sb.push_back(x);
    end
  endtask

  task automatic settle;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_drain(input int max_cycles);
    int k = 0;
    while (sb.size() != 0 && k < max_cycles) begin
      @(negedge clock);
      k++;
    end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: a beat is taken at the next rising edge when valid and ready are both high.
  initial begin
    exp_t act, req;
    forever begin
      @(negedge clock);
      #1;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        act.cycle = bus.out_cycle;  act.hartid = bus.out_hartid; act.iaddr = bus.out_iaddr;
        act.insn = bus.out_insn;    act.exception = bus.out_exception;
        act.interrupt = bus.out_interrupt; act.cause = bus.out_cause;
        act.has_wdata = bus.out_has_wdata; act.wdata = bus.out_wdata;
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_entry actual_iaddr=%0h required=none", act.iaddr);
        end else begin
          req = sb.pop_front();
          if (act !== req) begin
            n_fail++;
            $display("FAIL entry actual=%h required=%h", act, req);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; halt_on_overflow = 1'b0; bus.out_ready = 1'b0;
    cycle = '0; hartid = '0;
    bus.trace_valid = '0; bus.trace_exception = '0; bus.trace_interrupt = '0;
    bus.trace_has_wdata = '0; bus.trace_iaddr = '0; bus.trace_cause = '0;
    bus.trace_wdata = '0; bus.trace_insn = '0;
    #3;
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    chk("rst_out_iaddr", bus.out_iaddr, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Two valid lanes in one cycle, popped in lane order with the same stamp.
    begin_cycle(64'd7, 64'h11);
    bus.out_ready = 1'b1;
    set_lane(0, 1, 0, 0, 0, 64'h1000, 32'h0000_0013, 64'd0, 64'd0, 1);
    set_lane(1, 1, 0, 0, 0, 64'h1004, 32'h0010_0093, 64'd0, 64'd0, 1);
    settle;
    chk("latency_out_valid", 64'(bus.out_valid), 64'd1);
    chk("occ_after_pair", 64'(occupancy), 64'd2);
    begin_cycle(64'd8, 64'h11);
    wait_drain(10);

    // Cause alone is no event; exception-only and interrupt-only lanes are.
    begin_cycle(64'd20, 64'h22);
    set_lane(0, 0, 0, 0, 0, 64'h2000, 32'h0000_0013, 64'd5, 64'd0, 0);
    set_lane(1, 0, 1, 0, 0, 64'h2004, 32'h0000_0073, 64'd2, 64'd0, 1);
    begin_cycle(64'd21, 64'h22);
    set_lane(0, 1, 0, 0, 1, 64'h3000, 32'h00a0_0093, 64'd0, 64'hdead_beef_cafe_f00d, 1);
    set_lane(1, 0, 0, 1, 0, 64'h3004, 32'h0, 64'h8000_0000_0000_0007, 64'd0, 1);
    begin_cycle(64'd22, 64'h22);
    wait_drain(10);
    settle;
    chk("occ_after_flags", 64'(occupancy), 64'd0);

    // Fill to DEPTH with ready low, then a group that cannot fit.
    for (int k = 0; k < 8; k++) begin
      begin_cycle(64'(100 + k), 64'h33);
      bus.out_ready = 1'b0;
      set_lane(0, 1, 0, 0, 0, 64'(32'h4000 + 8*k), 32'h13, 64'd0, 64'd0, 1);
      set_lane(1, 1, 0, 0, 0, 64'(32'h4004 + 8*k), 32'h13, 64'd0, 64'd0, 1);
    end
    settle;
    chk("occ_full", 64'(occupancy), 64'd16);
    chk("no_overflow_yet", 64'(overflow), 64'd0);
    begin_cycle(64'd108, 64'h33);
    set_lane(0, 1, 0, 0, 0, 64'h4100, 32'h13, 64'd0, 64'd0, 0);
    set_lane(1, 1, 0, 0, 0, 64'h4104, 32'h13, 64'd0, 64'd0, 0);
    settle;
    chk("overflow_set", 64'(overflow), 64'd1);
    chk("drop_count_2", 64'(drop_count), 64'd2);
    chk("occ_stays_full", 64'(occupancy), 64'd16);

    // Full with a same-cycle pop: one event fits, two do not.
    begin_cycle(64'd109, 64'h33);
    bus.out_ready = 1'b1;
    set_lane(0, 1, 0, 0, 0, 64'h5000, 32'h13, 64'd0, 64'd0, 1);
    settle;
    chk("occ_push_pop_full", 64'(occupancy), 64'd16);
    chk("drop_count_still_2", 64'(drop_count), 64'd2);
    begin_cycle(64'd110, 64'h33);
    set_lane(0, 1, 0, 0, 0, 64'h5100, 32'h13, 64'd0, 64'd0, 0);
    set_lane(1, 1, 0, 0, 0, 64'h5104, 32'h13, 64'd0, 64'd0, 0);
    settle;
    chk("occ_after_pair_drop", 64'(occupancy), 64'd15);
    chk("drop_count_4", 64'(drop_count), 64'd4);
    begin_cycle(64'd111, 64'h33);
    wait_drain(40);
    settle;
    chk("occ_drained", 64'(occupancy), 64'd0);

    // Overflow without halt still accepts.
    begin_cycle(64'd200, 64'h44);
    bus.out_ready = 1'b0;
    set_lane(0, 1, 0, 0, 0, 64'h6000, 32'h13, 64'd0, 64'd0, 1);
    set_lane(1, 1, 0, 0, 0, 64'h6004, 32'h13, 64'd0, 64'd0, 1);
    settle;
    chk("occ_no_halt_accept", 64'(occupancy), 64'd2);

    // Halted: every group dropped and counted while the buffer drains.
    for (int k = 0; k < 4; k++) begin
      begin_cycle(64'(201 + k), 64'h44);
      halt_on_overflow = 1'b1;
      bus.out_ready    = 1'b1;
      set_lane(1, 0, 1, 0, 0, 64'(32'h7000 + 4*k), 32'h13, 64'd3, 64'd0, 0);
      settle;
      chk("halt_drop_count", 64'(drop_count), 64'(5 + k));
      chk("halt_occ", 64'(occupancy), (k < 2) ? 64'(1 - k) : 64'd0);
    end
    begin_cycle(64'd205, 64'h44);
    halt_on_overflow = 1'b0;
    wait_drain(5);
    chk("overflow_sticky", 64'(overflow), 64'd1);

    // Async reset with five entries buffered.
    begin_cycle(64'd300, 64'h55);
    bus.out_ready = 1'b0;
    set_lane(0, 1, 0, 0, 0, 64'h8000, 32'h13, 64'd0, 64'd0, 1);
    set_lane(1, 1, 0, 0, 0, 64'h8004, 32'h13, 64'd0, 64'd0, 1);
    begin_cycle(64'd301, 64'h55);
    set_lane(0, 1, 0, 0, 0, 64'h8008, 32'h13, 64'd0, 64'd0, 1);
    set_lane(1, 1, 0, 0, 0, 64'h800c, 32'h13, 64'd0, 64'd0, 1);
    begin_cycle(64'd302, 64'h55);
    set_lane(0, 1, 0, 0, 0, 64'h8010, 32'h13, 64'd0, 64'd0, 1);
    settle;
    chk("occ_five", 64'(occupancy), 64'd5);
    begin_cycle(64'd303, 64'h55);
    set_lane(0, 1, 0, 0, 0, 64'h8100, 32'h13, 64'd0, 64'd0, 0);
    set_lane(1, 1, 0, 0, 0, 64'h8104, 32'h13, 64'd0, 64'd0, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst_occ", 64'(occupancy), 64'd0);
    chk("async_rst_overflow", 64'(overflow), 64'd0);
    chk("async_rst_drop_count", 64'(drop_count), 64'd0);
    chk("async_rst_out_iaddr", bus.out_iaddr, 64'd0);
    sb.delete();
    settle;
    chk("rst_held_no_accept", 64'(occupancy), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    bus.trace_valid = '0;
    settle;
    chk("rst_release_no_accept", 64'(occupancy), 64'd0);

    // Normal operation resumes after reset.
    begin_cycle(64'd400, 64'h66);
    bus.out_ready = 1'b1;
    set_lane(0, 1, 0, 0, 1, 64'h9000, 32'h13, 64'd0, 64'h1234, 1);
    begin_cycle(64'd401, 64'h66);
    wait_drain(10);
    settle;
    chk("occ_final", 64'(occupancy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
